reg_wb_queue: RTL and testbench

Write-back queue that sits directly upstream of the register file's single write port. It accepts (address, data) results from execution through a valid/ready handshake and buffers them in a small in-order FIFO. It drains one entry per cycle onto the register file's `write_addr`/`write_data`/`write_ctrl` inputs whenever draining is enabled. An optional forwarding lookup lets operand fetch see pending results that have not yet reached the register file.

---
 rtl/reg_wb_queue.sv | 110 +++++++++++
 tb/tb_reg_wb_queue.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/reg_wb_queue.sv
// Write-back queue: buffers (addr, data) results in order and drains them to the register file write port.
// Latency: an entry pushed at edge N drives write_ctrl in cycle N+1; forwarding lookup is combinational.
// Backpressure: in_ready = !full (registered state only); drain stalls while drain_en is low.
// Optional macro WB_FWD_EN builds the forwarding comparators; without it look_hit/look_data are tied to 0.
module reg_wb_queue #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_WIDTH-1:0]      in_addr,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       drain_en,
  output logic                       write_ctrl,
  output logic [ADDR_WIDTH-1:0]      write_addr,
  output logic [DATA_WIDTH-1:0]      write_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  input  logic [ADDR_WIDTH-1:0]      look_addr,
  output logic                       look_hit,
  output logic [DATA_WIDTH-1:0]      look_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] r_addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_data_mem [DEPTH];
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_wr_ptr;
  logic [CW-1:0]         r_count;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_push     = in_valid & ~w_full;
  assign w_pop      = drain_en & ~w_empty;

  assign in_ready   = ~w_full;
  assign full       = w_full;
  assign empty      = w_empty;
  assign count      = r_count;
  assign write_ctrl = w_pop;
  assign write_addr = r_addr_mem[r_rd_ptr];
  assign write_data = r_data_mem[r_rd_ptr];

  // Entry storage: written at the tail on push, cleared on reset so outputs start at 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_addr_mem[i] <= '0;
        r_data_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_addr_mem[r_wr_ptr] <= in_addr;
      r_data_mem[r_wr_ptr] <= in_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef WB_FWD_EN
  logic                  w_look_hit;
  logic [DATA_WIDTH-1:0] w_look_data;

  // Walk occupied entries oldest-to-newest so a later match overrides an earlier one.
  always_comb begin
    w_look_hit  = 1'b0;
    w_look_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < r_count) && (r_addr_mem[r_rd_ptr + PW'(i)] == look_addr)) begin
        w_look_hit  = 1'b1;
        w_look_data = r_data_mem[r_rd_ptr + PW'(i)];
      end
    end
  end

  assign look_hit  = w_look_hit;
  assign look_data = w_look_data;
`else
  logic w_look_unused;
  assign w_look_unused = ^look_addr;
  assign look_hit      = 1'b0;
  assign look_data     = '0;
`endif

endmodule

// File: tb/tb_reg_wb_queue.sv
module tb_reg_wb_queue;

  logic       clock;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_addr;
  logic [7:0] in_data;
  logic       drain_en;
  logic       write_ctrl;
  logic [7:0] write_addr;
  logic [7:0] write_data;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic [7:0] look_addr;
  logic       look_hit;
  logic [7:0] look_data;

  int checks = 0;
  int errors = 0;

  reg_wb_queue #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .drain_en(drain_en), .write_ctrl(write_ctrl), .write_addr(write_addr), .write_data(write_data),
    .count(count), .full(full), .empty(empty),
    .look_addr(look_addr), .look_hit(look_hit), .look_data(look_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full clock: the posedge commits, then return at the following negedge.
  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_addr   = '0;
    in_data   = '0;
    drain_en  = 1'b1;
    look_addr = '0;
    #12;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_write_ctrl", write_ctrl, 0);
    chk("rst_write_addr", write_addr, 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_look_hit", look_hit, 0);
    chk("rst_look_data", look_data, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // Single entry pass-through
    in_valid = 1'b1; in_addr = 8'd3; in_data = 8'h5A;
    cyc();
    in_valid = 1'b0;
    #1;
    chk("t1_write_ctrl", write_ctrl, 1);
    chk("t1_write_addr", write_addr, 3);
    chk("t1_write_data", write_data, 8'h5A);
    chk("t1_count", count, 1);
    cyc();
    chk("t1_empty", empty, 1);
    chk("t1_ctrl_idle", write_ctrl, 0);

    // Fill to full with drain held off
    drain_en = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_addr = 8'(i); in_data = 8'(i * 8'h11);
      cyc();
    end
    in_valid = 1'b0;
    #1;
    chk("t2_full", full, 1);
    chk("t2_in_ready", in_ready, 0);
    chk("t2_count", count, 4);
    chk("t2_ctrl_held", write_ctrl, 0);
    in_valid = 1'b1; in_addr = 8'd9; in_data = 8'h99;
    cyc();
    in_valid = 1'b0;
    chk("t2_reject_count", count, 4);
    drain_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("t2_drain_ctrl", write_ctrl, 1);
      chk("t2_drain_addr", write_addr, 32'(i));
      chk("t2_drain_data", write_data, 32'(i * 8'h11));
      cyc();
    end
    chk("t2_empty", empty, 1);
    chk("t2_no_ninth", write_ctrl, 0);

    // Streaming push+pop across pointer wrap
    in_valid = 1'b1; in_addr = 8'd20; in_data = 8'hA0;
    cyc();
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("t3_count", count, 1);
      chk("t3_ctrl", write_ctrl, 1);
      chk("t3_addr", write_addr, 32'(20 + k));
      chk("t3_data", write_data, 32'(8'hA0 + k));
      if (k < 9) begin
        in_addr = 8'(21 + k); in_data = 8'(8'hA1 + k);
      end else begin
        in_valid = 1'b0;
      end
      cyc();
    end
    chk("t3_empty", empty, 1);

    // Forwarding with duplicate addresses
    drain_en = 1'b0;
    in_valid = 1'b1; in_addr = 8'd7; in_data = 8'h10;
    cyc();
    in_data = 8'h20;
    cyc();
    in_valid = 1'b0;
    look_addr = 8'd7;
    #1;
    chk("t4_head_addr", write_addr, 7);
    chk("t4_head_data", write_data, 8'h10);
`ifdef WB_FWD_EN
    chk("t4_hit7", look_hit, 1);
    chk("t4_data7", look_data, 8'h20);
`else
    chk("t4_hit7_off", look_hit, 0);
    chk("t4_data7_off", look_data, 0);
`endif
    look_addr = 8'd8;
    #1;
    chk("t4_miss8", look_hit, 0);
    in_valid = 1'b1; in_addr = 8'd8; in_data = 8'h30;
    #1;
    chk("t4_pushing_not_seen", look_hit, 0);
    cyc();
    in_valid = 1'b0;
    #1;
    chk("t4_count3", count, 3);
`ifdef WB_FWD_EN
    chk("t4_hit8", look_hit, 1);
    chk("t4_data8", look_data, 8'h30);
`else
    chk("t4_hit8_off", look_hit, 0);
`endif

    // Mid-cycle reset with 3 pending entries
    drain_en = 1'b1;
    #1;
    reset_n = 1'b0;
    #1;
    chk("t5_count", count, 0);
    chk("t5_ctrl", write_ctrl, 0);
    chk("t5_in_ready", in_ready, 1);
    chk("t5_empty", empty, 1);
    chk("t5_write_addr", write_addr, 0);
    chk("t5_look_hit", look_hit, 0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t5_no_stale_write", write_ctrl, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
